// File: rtl/mem_access_unit.sv
// Load/store front end for the data RAM: byte-addressed requests become
// word-indexed RAM accesses, with read-modify-write for sub-word stores and
// lane select plus sign/zero extension for loads.
module mem_access_unit #(
    parameter int unsigned SIZE = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] ram_index_r,
    output logic [31:0] ram_index_w,
    output logic        ram_wr_en,
    output logic [31:0] ram_entry,
    input  logic [31:0] ram_entry_out
);

    typedef enum logic [2:0] {StIdle, StRdIssue, StRdData, StWrite, StResp} state_e;

    state_e      state;
    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [1:0]  cap_lane;
    logic [31:0] cap_wdata;
    logic [31:0] cap_index;

    logic [31:0] req_index;
    logic        req_err;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    assign req_ready = (state == StIdle);
    assign req_index = {2'b00, req_addr[31:2]};

    // Request legality: size code, natural alignment and RAM bounds.
    always_comb begin
        req_err = 1'b0;
        unique case (req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            2'b10:   req_err = |req_addr[1:0];
            default: req_err = 1'b1;
        endcase
        if (req_index >= SIZE) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        shamt     = {cap_lane, 3'b000};
        shifted   = ram_entry_out >> shamt;
        lane_mask = ((cap_size == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
        unique case (cap_size)
            2'b00:   load_data = cap_unsigned ? {24'h0, shifted[7:0]}
                                              : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = cap_unsigned ? {16'h0, shifted[15:0]}
                                              : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = ram_entry_out;
        endcase
        merge_data = (ram_entry_out & ~lane_mask) | ((cap_wdata << shamt) & lane_mask);
    end

    // Control FSM with all RAM and response outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            cap_we       <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_lane     <= 2'b00;
            cap_wdata    <= 32'h0;
            cap_index    <= 32'h0;
            resp_valid   <= 1'b0;
            resp_rdata   <= 32'h0;
            resp_err     <= 1'b0;
            ram_index_r  <= 32'h0;
            ram_index_w  <= 32'h0;
            ram_wr_en    <= 1'b0;
            ram_entry    <= 32'h0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        cap_we       <= req_we;
                        cap_size     <= req_size;
                        cap_unsigned <= req_unsigned;
                        cap_lane     <= req_addr[1:0];
                        cap_wdata    <= req_wdata;
                        cap_index    <= req_index;
                        if (req_err) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                            state      <= StResp;
                        end else if (req_we && req_size == 2'b10) begin
                            ram_index_w <= req_index;
                            ram_entry   <= req_wdata;
                            ram_wr_en   <= 1'b1;
                            state       <= StWrite;
                        end else begin
                            ram_index_r <= req_index;
                            state       <= StRdIssue;
                        end
                    end
                end
                StRdIssue: begin
                    state <= StRdData;
                end
                StRdData: begin
                    if (cap_we) begin
                        ram_index_w <= cap_index;
                        ram_entry   <= merge_data;
                        ram_wr_en   <= 1'b1;
                        state       <= StWrite;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                        state      <= StResp;
                    end
                end
                StWrite: begin
                    ram_wr_en  <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                    state      <= StResp;
                end
                StResp: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    state      <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
